// File: rtl/arith_result_checker.sv
// Response monitor for the 4-bit arithmetic circuit: recomputes a+Y+cin,
// counts pass/fail per run and captures the first mismatching vector.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           clear results and begin a run (priority over vld/last)
//   vld, last       vector valid, end of stream (last sampled only in RUN)
//   a, b, s1, s0,
//   cin, d, cout    circuit stimulus and response
//   busy, done      run status (RUN/DRAIN, DONE)
//   all_pass        done with at least one pass and no fails
//   pass_cnt,
//   fail_cnt        saturating verdict counters
//   ff_*            first-fail record: op, operands, got and expected {cout,d}
module arith_result_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             last,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             s1,
  input  logic             s0,
  input  logic             cin,
  input  logic [3:0]       d,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_vld,
  output logic [2:0]       ff_op,
  output logic [3:0]       ff_a,
  output logic [3:0]       ff_b,
  output logic [4:0]       ff_got,
  output logic [4:0]       ff_exp
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] pass_q;
  logic [CNT_W-1:0] fail_q;
  logic             ff_vld_q;
  logic [2:0]       ff_op_q;
  logic [3:0]       ff_a_q;
  logic [3:0]       ff_b_q;
  logic [4:0]       ff_got_q;
  logic [4:0]       ff_exp_q;

  // Stage 1: sampled vector and response
  logic       s1_vld_q;
  logic [3:0] s1_a_q;
  logic [3:0] s1_b_q;
  logic [2:0] s1_op_q;
  logic [3:0] s1_d_q;
  logic       s1_cout_q;

  logic [3:0]       y;
  logic [4:0]       exp_v;
  logic [4:0]       got_v;
  logic             mism;
  logic             accept;
  logic [CNT_W-1:0] pass_d;
  logic [CNT_W-1:0] fail_d;

  always_comb begin
    y = s1_b_q;
    unique case (s1_op_q[2:1])
      2'b00: y = s1_b_q;
      2'b01: y = ~s1_b_q;
      2'b10: y = 4'b0000;
      2'b11: y = 4'b1111;
      default: y = s1_b_q;
    endcase
  end

  assign exp_v  = {1'b0, s1_a_q} + {1'b0, y} + {4'b0000, s1_op_q[0]};
  assign got_v  = {s1_cout_q, s1_d_q};
  assign mism   = (got_v != exp_v);
  assign accept = (state_q == RUN) && vld;

  // Saturating increments
  assign pass_d = (pass_q == CNT_MAX) ? pass_q : pass_q + 1'b1;
  assign fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      ff_vld_q  <= 1'b0;
      ff_op_q   <= '0;
      ff_a_q    <= '0;
      ff_b_q    <= '0;
      ff_got_q  <= '0;
      ff_exp_q  <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_op_q   <= '0;
      s1_d_q    <= '0;
      s1_cout_q <= 1'b0;
    end else if (start) begin
      state_q   <= RUN;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      ff_vld_q  <= 1'b0;
      ff_op_q   <= '0;
      ff_a_q    <= '0;
      ff_b_q    <= '0;
      ff_got_q  <= '0;
      ff_exp_q  <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_a_q    <= a;
        s1_b_q    <= b;
        s1_op_q   <= {s1, s0, cin};
        s1_d_q    <= d;
        s1_cout_q <= cout;
      end
      if (s1_vld_q) begin
        if (mism) begin
          fail_q <= fail_d;
          if (!ff_vld_q) begin
            ff_vld_q <= 1'b1;
            ff_op_q  <= s1_op_q;
            ff_a_q   <= s1_a_q;
            ff_b_q   <= s1_b_q;
            ff_got_q <= got_v;
            ff_exp_q <= exp_v;
          end
        end else begin
          pass_q <= pass_d;
        end
      end
      unique case (state_q)
        IDLE: ;
        RUN: begin
          if (last) state_q <= DRAIN;
        end
        // Stage 1 empties on this edge since DRAIN accepts nothing
        DRAIN: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign all_pass = done_q && (fail_q == '0) && (pass_q != '0);
  assign pass_cnt = pass_q;
  assign fail_cnt = fail_q;
  assign ff_vld   = ff_vld_q;
  assign ff_op    = ff_op_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_got   = ff_got_q;
  assign ff_exp   = ff_exp_q;

endmodule

// File: doc/arith_result_checker.md
# arith_result_checker

Synthesizable, self-checking response monitor for the 4-bit arithmetic circuit.
- Stimulus side drives the circuit's A, B, S1, S0, Cin; this block samples those same values plus the circuit's D and Cout.
- It recomputes the expected result, then keeps pass/fail counts and captures the first mismatching vector.
- Used in on-chip BIST and in the simulation bench as the receiving end of the vector stream, so the stimulus side needs no hand-written expected values.

## Interface
Parameters:
- CNT_W, default 8, width of the pass/fail counters.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse: clear all results and begin a run.
- vld  in  1  vector/response on the inputs below is valid this cycle.
- last  in  1  marks end of stream; sampled only in RUN.
- a, b  in  4 each  circuit operands.
- s1, s0, cin  in  1 each  circuit function select and carry-in.
- d  in  4  circuit result.
- cout  in  1  circuit carry-out.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- all_pass  out  1  done && fail_cnt==0 && pass_cnt!=0.
- pass_cnt  out  CNT_W  matching vectors, saturating.
- fail_cnt  out  CNT_W  mismatching vectors, saturating.
- ff_vld  out  1  first-fail record valid.
- ff_op  out  3  {s1,s0,cin} of the first failing vector.
- ff_a, ff_b  out  4 each  operands of the first failing vector.
- ff_got  out  5  {cout,d} received for the first failing vector.
- ff_exp  out  5  {cout,d} expected for the first failing vector.

## Operation
Expected value: exp[4:0] = a + Y + cin, 5-bit unsigned sum; exp[3:0] is D and exp[4] is Cout. Y is selected by {s1,s0}:
- 00: Y = b.
- 01: Y = ~b.
- 10: Y = 4'b0000.
- 11: Y = 4'b1111.

FSM states are IDLE, RUN, DRAIN and DONE.
- Reset state is IDLE.
- IDLE -> RUN on start.
- RUN -> DRAIN when last is sampled high (with or without vld).
- DRAIN -> DONE when no vector remains in the pipeline.
- DONE holds until the next start.

Start handling:
- start in any state, including RUN and DRAIN, clears counters, ff_* and the pipeline, then enters RUN.
- start has priority over vld and last in the same cycle.
- A vector presented together with start is discarded.

Pipeline and result updates:
- Stage 1: in RUN, vld=1 registers a, b, s1, s0, cin, d, cout and a valid bit.
- vld is ignored in IDLE, DRAIN and DONE.
- Stage 2: compares registered {cout,d} with exp computed from the registered operands, then updates pass_cnt or fail_cnt (exactly one).
- On the first mismatch of a run, the first-fail record is loaded and ff_vld is set.
- Later mismatches do not overwrite the first-fail record.
- Counters stop at 2^CNT_W-1 and never wrap.

Boundary cases:
- vld and last in the same RUN cycle: the vector is accepted and is the final one checked.
- last with no vector accepted: the run ends with pass_cnt=0, so all_pass=0.
- Back-to-back vld, one per cycle, is supported with no stall.

## Timing
- Synchronous reset (rst_n low at an edge) sets all outputs to 0: busy, done, all_pass, pass_cnt, fail_cnt, ff_vld, ff_op, ff_a, ff_b, ff_got, ff_exp. The pipeline valid bit is cleared.
- Reset asserted mid-run aborts the run, leaves the FSM in IDLE and produces no done.
- Vector sampled at edge k: its counter and ff_* update at edge k+1 and are visible after that edge. Latency is 2 edges from vld to counter.
- last sampled at edge k:
  - DRAIN is visible after edge k.
  - DONE is visible after edge k+1, and the final counter update lands at that same edge.
  - done and all_pass are therefore consistent in the first DONE cycle.
- start at edge k: busy=1, done=0 and counters=0 are visible after edge k.

## Test plan
- Correct circuit, A=5, B=2, eight vectors {s1,s0,cin}=000..111 with last on the 8th. Expected {cout,d} in order: 0_0111, 0_1000, 1_0010, 1_0011, 0_0101, 0_0110, 1_0100, 1_0101. Required: pass_cnt=8, fail_cnt=0, all_pass=1, done exactly 2 edges after last.
- Same stream with the 3rd response forced to d=4'b0010, cout=0. Required: fail_cnt=1, pass_cnt=7, ff_op=3'b010, ff_got=5'h02, ff_exp=5'h12, all_pass=0.
- Two corrupted vectors (3rd and 6th). Required: fail_cnt=2, and ff_* still describe the 3rd vector.
- Exhaustive stream of 256×8 vectors with CNT_W=8 and a correct circuit. Required: pass_cnt saturates at 255, fail_cnt=0.
- rst_n low mid-run after 3 vectors. Required: all outputs 0, FSM in IDLE, vld ignored until start.
- start pulsed in DRAIN. Required: counters clear and RUN re-entered; the draining vector is not counted.
